serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//   Bit-serial WIDTH-bit subtractor with borrow-in: DIFF = A - B - Bin, Bout = borrow out of the MSB.
//   Inverse-direction companion to the combinational binary_adder: trades area for WIDTH cycles of latency.
//   Sits behind a start/done handshake on the datapath clock so a controller or bench can check
//   adder/subtractor round trips (A + B + Cin, then SUM - B - Cin == A).
// PARAMETERS
//   WIDTH  8  operand/result width in bits (>= 2)
// PORTS
//   clk    input   1      rising-edge clock, sole clock domain
//   rst_n  input   1      synchronous reset, active-low, sampled on rising clk
//   start  input   1      request; sampled only in IDLE
//   A      input   WIDTH  minuend, captured on accepted start
//   B      input   WIDTH  subtrahend, captured on accepted start
//   Bin    input   1      borrow-in, captured on accepted start
//   busy   output  1      high while state == SHIFT
//   done   output  1      one-cycle pulse, result valid
//   DIFF   output  WIDTH  registered difference, held until next completion
//   Bout   output  1      registered borrow-out, held until next completion
// BEHAVIOUR
//   Reset (rst_n=0 at an edge): state=IDLE, busy=0, done=0, DIFF=0, Bout=0, internal shift regs,
//     borrow and counter cleared. Applies from any state; an in-flight operation is discarded, no done.
//   States: IDLE, SHIFT, DONE.
//   IDLE: busy=0, done=0. start=1 at edge k -> latch A,B into shift regs, borrow<=Bin, cnt<=0, go SHIFT.
//   SHIFT: one bit per edge, LSB first: a=a_sr[0], b=b_sr[0], br=borrow;
//     d = a^b^br; borrow <= (~a&b) | (~(a^b)&br); d shifted into result reg MSB end; a_sr,b_sr shift right.
//     Edges k+1..k+WIDTH process bits 0..WIDTH-1; on edge with cnt==WIDTH-1 go DONE,
//     DIFF <= completed result, Bout <= final borrow. cnt wraps never (cleared on accept).
//   DONE: done=1 for exactly one cycle (cycle after edge k+WIDTH); next edge -> IDLE unconditionally.
//   Latency: start sampled at edge k -> done high after edge k+WIDTH; next start accepted at edge k+WIDTH+2.
//   start while SHIFT or DONE: ignored, no queuing; A/B/Bin changes after capture have no effect.
//   start held high continuously: back-to-back ops, one every WIDTH+2 cycles.
//   DIFF/Bout change only at completion edge; stable during busy (show previous result).
//   Arithmetic: modulo 2^WIDTH; Bout=1 iff A < B + Bin (unsigned). A=B, Bin=0 -> DIFF=0, Bout=0.
//   No X propagation: all regs reset; outputs are direct register outputs (no combinational paths).
// TESTING
//   1) A=8'h01,B=8'h01,Bin=0, start pulse -> busy 8 cycles, done 1 cycle at edge+8, DIFF=8'h00,Bout=0.
//   2) A=8'hFF,B=8'h00,Bin=1 -> DIFF=8'hFE,Bout=0; A=8'h55,B=8'h01,Bin=0 -> DIFF=8'h54,Bout=0.
//   3) Wrap: A=8'h00,B=8'h01,Bin=0 -> DIFF=8'hFF,Bout=1; A=8'h99,B=8'h99,Bin=1 -> DIFF=8'hFF,Bout=1.
//   4) Round trip: feed binary_adder vectors (8'h67+8'h01+1=8'h69) as A=8'h69,B=8'h01,Bin=1 -> DIFF=8'h67,Bout=0.
//   5) start re-pulsed with new A/B during busy -> ignored; result matches first operands; done count=1.
//   6) rst_n=0 for 1 cycle at bit 4 of an op -> busy=0,done=0,DIFF=0,Bout=0 next cycle; no done follows;
//      fresh start then completes normally in 8 cycles.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// Start/done handshake bundle for the bit-serial subtractor.
// The controller (master) drives the request and operands. The subtractor (slave)
// returns its status and the registered result.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] DIFF;
    logic             Bout;

    modport master (
        output start, A, B, Bin,
        input  busy, done, DIFF, Bout
    );

    modport slave (
        input  start, A, B, Bin,
        output busy, done, DIFF, Bout
    );
endinterface : serial_subtractor_if

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: DIFF = A - B - Bin, Bout = borrow out of the MSB.
// One bit is resolved per clock, LSB first, so a result takes WIDTH cycles.
// All outputs are driven straight from registers. DIFF and Bout hold the previous
// result until the next operation completes.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Full-subtractor cell. The result is {borrow_out, difference_bit}.
    function automatic logic [1:0] sub_bit(input logic a, input logic b, input logic br);
        logic d;
        logic bo;
        d  = a ^ b ^ br;
        bo = (~a & b) | (~(a ^ b) & br);
        return {bo, d};
    endfunction

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_sr_q, a_sr_d;
    logic [WIDTH-1:0]  b_sr_q, b_sr_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic              borrow_q, borrow_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  diff_q, diff_d;
    logic              bout_q, bout_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [1:0]        cell_s;

    // Next-state, datapath shift and output-flag computation.
    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_d    = res_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        cell_s   = sub_bit(a_sr_q[0], b_sr_q[0], borrow_q);

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_sr_d   = bus.A;
                    b_sr_d   = bus.B;
                    borrow_d = bus.Bin;
                    cnt_d    = {CNT_W{1'b0}};
                    state_d  = SHIFT;
                end else begin
                    state_d  = IDLE;
                end
            end
            SHIFT: begin
                // Shift the difference bit in at the MSB end so that after WIDTH
                // edges the LSB has reached bit 0.
                res_d    = {cell_s[0], res_q[WIDTH-1:1]};
                borrow_d = cell_s[1];
                a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
                if (cnt_q == LAST_BIT) begin
                    diff_d  = {cell_s[0], res_q[WIDTH-1:1]};
                    bout_d  = cell_s[1];
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The status flags are registered alongside the state, so they track it exactly.
        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    // State, datapath and output registers with a synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sr_q   <= {WIDTH{1'b0}};
            b_sr_q   <= {WIDTH{1'b0}};
            res_q    <= {WIDTH{1'b0}};
            borrow_q <= 1'b0;
            cnt_q    <= {CNT_W{1'b0}};
            diff_q   <= {WIDTH{1'b0}};
            bout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_q    <= res_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.DIFF = diff_q;
    assign bus.Bout = bout_q;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8).
// The stimulus pushes a hand-computed {DIFF,Bout} for each operation. A monitor pops
// and compares the expected value on every done pulse.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    logic [7:0] last_diff = 8'h00;
    logic [8:0] exp_q[$];

    serial_subtractor_if #(.WIDTH(8)) bus ();

    serial_subtractor #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: pops and compares one expected result on every done pulse.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                check("diff", {24'd0, bus.DIFF}, {24'd0, e[8:1]});
                check("bout", {31'd0, bus.Bout}, {31'd0, e[0]});
            end
        end
    end

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                          input logic [7:0] ed, input logic eb, input bit repulse);
        int lat;
        int bcnt;
        int d0;
        lat  = 0;
        bcnt = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.A = a;
        bus.B = b;
        bus.Bin = bin;
        exp_q.push_back({ed, eb});
        d0 = done_cnt;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus.start = 1'b0;
                bus.A = ~a;
                bus.B = ~b;
                bus.Bin = ~bin;
                check("diff_stable", {24'd0, bus.DIFF}, {24'd0, last_diff});
            end
            if (repulse && c == 3) begin
                bus.start = 1'b1;
                bus.A = 8'hFF;
                bus.B = 8'h00;
            end
            if (repulse && c == 4) bus.start = 1'b0;
            if (bus.busy === 1'b1) bcnt++;
            if (bus.done === 1'b1) begin
                lat = c;
                break;
            end
        end
        check("latency", lat, 32'd9);
        check("busy_cycles", bcnt, 32'd8);
        @(negedge clk);
        check("done_one_cycle", {31'd0, bus.done}, 32'd0);
        check("done_count", done_cnt - d0, 32'd1);
        last_diff = ed;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.A = 8'h00;
        bus.B = 8'h00;
        bus.Bin = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_diff", {24'd0, bus.DIFF}, 32'd0);
        check("rst_bout", {31'd0, bus.Bout}, 32'd0);
        rst_n = 1'b1;

        run_op(8'h01, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0);
        run_op(8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0, 1'b0);
        run_op(8'h55, 8'h01, 1'b0, 8'h54, 1'b0, 1'b0);
        run_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
        run_op(8'h99, 8'h99, 1'b1, 8'hFF, 1'b1, 1'b0);
        run_op(8'h69, 8'h01, 1'b1, 8'h67, 1'b0, 1'b0);
        // A start pulse during busy is ignored, so the result comes from the first operands.
        run_op(8'h30, 8'h10, 1'b0, 8'h20, 1'b0, 1'b1);

        // Reset while bit 4 is being processed: the operation is discarded.
        begin
            int d0;
            d0 = done_cnt;
            @(negedge clk);
            bus.start = 1'b1;
            bus.A = 8'h12;
            bus.B = 8'h34;
            bus.Bin = 1'b0;
            for (int c = 1; c <= 5; c++) begin
                @(negedge clk);
                if (c == 1) bus.start = 1'b0;
                if (c == 5) rst_n = 1'b0;
            end
            @(negedge clk);
            check("abort_busy", {31'd0, bus.busy}, 32'd0);
            check("abort_done", {31'd0, bus.done}, 32'd0);
            check("abort_diff", {24'd0, bus.DIFF}, 32'd0);
            check("abort_bout", {31'd0, bus.Bout}, 32'd0);
            rst_n = 1'b1;
            last_diff = 8'h00;
            repeat (15) @(negedge clk);
            check("abort_no_done", done_cnt - d0, 32'd0);
        end
        run_op(8'h80, 8'h01, 1'b1, 8'h7E, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_serial_subtractor
